// File: rtl/cmod_s7_pkg.sv
// Shared types and constants for the CmodS7 LED driver.
// Also holds constant helpers for sizing the timing counters.
package cmod_s7_pkg;

    localparam int LED_MODE_W = 2;
    localparam int MS_PER_S   = 1000;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    // PWM tick divider, floored and never below 1.
    function automatic int unsigned pwm_div(input int unsigned clk_hz,
                                            input int unsigned pwm_hz,
                                            input int unsigned bits);
        int unsigned d;
        d = clk_hz / (pwm_hz * (32'd1 << bits));
        return (d == 0) ? 32'd1 : d;
    endfunction

    function automatic int cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config registers, pending flag and mode mux.
// Define CMOD_S7_LED_BREATHE_EN to scale the level by the shared breathe ramp in mode 3.
module led_pwm_channel
    import cmod_s7_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we_i,
    input  logic [LED_MODE_W-1:0] cfg_mode_i,
    input  logic [PWM_BITS-1:0]   cfg_level_i,
    input  logic                  wrap_i,
    input  logic [PWM_BITS-1:0]   pwm_cnt_i,
    input  logic                  blink_phase_i,
`ifdef CMOD_S7_LED_BREATHE_EN
    input  logic [PWM_BITS-1:0]   breathe_lvl_i,
`endif
    output logic                  pending_o,
    output logic                  raw_o
);

    led_mode_t             act_mode_q, act_mode_d;
    led_mode_t             shd_mode_q, shd_mode_d;
    logic [PWM_BITS-1:0]   act_lvl_q, act_lvl_d;
    logic [PWM_BITS-1:0]   shd_lvl_q, shd_lvl_d;
    logic                  pending_q, pending_d;
    logic [PWM_BITS-1:0]   eff_lvl;
    logic                  on_term;

`ifdef CMOD_S7_LED_BREATHE_EN
    logic [2*PWM_BITS-1:0] breathe_prod;
    assign breathe_prod = act_lvl_q * breathe_lvl_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_mode_q <= LED_OFF;
            shd_mode_q <= LED_OFF;
            act_lvl_q  <= '0;
            shd_lvl_q  <= '0;
            pending_q  <= 1'b0;
        end else begin
            act_mode_q <= act_mode_d;
            shd_mode_q <= shd_mode_d;
            act_lvl_q  <= act_lvl_d;
            shd_lvl_q  <= shd_lvl_d;
            pending_q  <= pending_d;
        end
    end

    // A write landing on the wrap cycle skips the shadow so it is not deferred a whole period.
    always_comb begin
        act_mode_d = act_mode_q;
        act_lvl_d  = act_lvl_q;
        shd_mode_d = shd_mode_q;
        shd_lvl_d  = shd_lvl_q;
        pending_d  = pending_q;
        if (cfg_we_i) begin
            shd_mode_d = led_mode_t'(cfg_mode_i);
            shd_lvl_d  = cfg_level_i;
            if (wrap_i) begin
                act_mode_d = led_mode_t'(cfg_mode_i);
                act_lvl_d  = cfg_level_i;
                pending_d  = 1'b0;
            end else begin
                pending_d  = 1'b1;
            end
        end else if (wrap_i && pending_q) begin
            act_mode_d = shd_mode_q;
            act_lvl_d  = shd_lvl_q;
            pending_d  = 1'b0;
        end
    end

    always_comb begin
        eff_lvl = act_lvl_q;
`ifdef CMOD_S7_LED_BREATHE_EN
        if (act_mode_q == LED_BREATHE) begin
            eff_lvl = breathe_prod[2*PWM_BITS-1:PWM_BITS];
        end
`endif
        on_term = (&eff_lvl) | (pwm_cnt_i < eff_lvl);
        case (act_mode_q)
            LED_OFF:     raw_o = 1'b0;
            LED_ON:      raw_o = on_term;
            LED_BLINK:   raw_o = on_term & blink_phase_i;
            LED_BREATHE: raw_o = on_term;
            default:     raw_o = 1'b0;
        endcase
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/cmod_s7_led_driver.sv
// CmodS7 user-LED driver: PWM prescaler, ms/blink timing and LED_DW config-driven channels.
// Define CMOD_S7_LED_BREATHE_EN to build the shared triangle breathe generator for mode 3.
module cmod_s7_led_driver
    import cmod_s7_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int LED_DW     = 4,
    parameter int PWM_BITS   = 8,
    parameter int PWM_FREQ   = 1000,
    parameter int BLINK_MS   = 250,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid_i,
    input  logic [$clog2(LED_DW)-1:0]  cfg_ch_i,
    input  logic [LED_MODE_W-1:0]      cfg_mode_i,
    input  logic [PWM_BITS-1:0]        cfg_level_i,
    output logic                       cfg_pending_o,
    output logic [LED_DW-1:0]          led_o
);

    localparam int unsigned DIV     = pwm_div(CLK_FREQ, PWM_FREQ, PWM_BITS);
    localparam int unsigned MS_DIV  = (CLK_FREQ / MS_PER_S > 0) ? CLK_FREQ / MS_PER_S : 1;
    localparam int          DIV_W   = cnt_width(DIV);
    localparam int          MS_W    = cnt_width(MS_DIV);
    localparam int          BLINK_W = cnt_width(BLINK_MS);
    localparam int          CH_W    = $clog2(LED_DW);
    localparam logic [LED_DW-1:0] LED_IDLE = {LED_DW{ACTIVE_LOW != 0}};

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [LED_DW-1:0]   led_q, led_d;
    logic [LED_DW-1:0]   raw_vec;
    logic [LED_DW-1:0]   pending_vec;
    logic                pwm_tick, ms_tick, wrap;

    assign pwm_tick = (div_cnt_q == DIV_W'(DIV - 1));
    assign wrap     = pwm_tick & (&pwm_cnt_q);
    assign ms_tick  = (ms_cnt_q == MS_W'(MS_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            ms_cnt_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_q         <= LED_IDLE;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            ms_cnt_q      <= ms_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
        end
    end

    always_comb begin
        div_cnt_d     = pwm_tick ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d     = pwm_tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        ms_cnt_d      = ms_tick ? '0 : ms_cnt_q + MS_W'(1);
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (ms_tick) begin
            if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
            end
        end
        led_d = raw_vec ^ LED_IDLE;
    end

`ifdef CMOD_S7_LED_BREATHE_EN
    logic [PWM_BITS-1:0] breathe_lvl_q, breathe_lvl_d;
    logic                breathe_up_q, breathe_up_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            breathe_lvl_q <= '0;
            breathe_up_q  <= 1'b1;
        end else begin
            breathe_lvl_q <= breathe_lvl_d;
            breathe_up_q  <= breathe_up_d;
        end
    end

    // Triangle ramp: one step per PWM period, turning around at both ends.
    always_comb begin
        breathe_lvl_d = breathe_lvl_q;
        breathe_up_d  = breathe_up_q;
        if (wrap) begin
            if (breathe_up_q) begin
                if (&breathe_lvl_q) begin
                    breathe_up_d  = 1'b0;
                    breathe_lvl_d = breathe_lvl_q - PWM_BITS'(1);
                end else begin
                    breathe_lvl_d = breathe_lvl_q + PWM_BITS'(1);
                end
            end else begin
                if (breathe_lvl_q == '0) begin
                    breathe_up_d  = 1'b1;
                    breathe_lvl_d = PWM_BITS'(1);
                end else begin
                    breathe_lvl_d = breathe_lvl_q - PWM_BITS'(1);
                end
            end
        end
    end
`endif

    // Out-of-range channel numbers match no instance, so such writes simply vanish.
    for (genvar g = 0; g < LED_DW; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .cfg_we_i     (cfg_valid_i && (cfg_ch_i == CH_W'(g))),
            .cfg_mode_i   (cfg_mode_i),
            .cfg_level_i  (cfg_level_i),
            .wrap_i       (wrap),
            .pwm_cnt_i    (pwm_cnt_q),
            .blink_phase_i(blink_phase_q),
`ifdef CMOD_S7_LED_BREATHE_EN
            .breathe_lvl_i(breathe_lvl_q),
`endif
            .pending_o    (pending_vec[g]),
            .raw_o        (raw_vec[g])
        );
    end

    assign cfg_pending_o = |pending_vec;
    assign led_o         = led_q;

endmodule
